// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package keypad_pkg;

    // Classification of one completed full-matrix scan.
    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } res_kind_t;

    // Key event state.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_t;

    // Column drive out of reset: column 0 selected (one-hot-low).
    localparam logic [3:0] COL_RESET = 4'b1110;

    // Row-major key codes, index = {row, col}.
    // Row 3 carries '*' as E and '#' as F.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        return KEY_MAP[{r, c}];
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the debounced key event outputs.
// Latency: n/a (wiring only).
// Backpressure: none; key_valid is a one-cycle pulse with no ready.
// Ports: col (column drive, one-hot-low), row (active-low row sense),
//        key_char ({4'h0, code}), key_valid (press pulse), key_down (held level).
interface keypad_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [7:0] key_char;
    logic       key_valid;
    logic       key_down;

    // Scanner side.
    modport master (
        output col,
        output key_char,
        output key_valid,
        output key_down,
        input  row
    );

    // Keypad / consumer side.
    modport slave (
        input  col,
        input  key_char,
        input  key_valid,
        input  key_down,
        output row
    );
endinterface

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchronizer for the asynchronous row sense lines.
// Latency: 2 clk cycles.
// Backpressure: none.
// Ports: clk, rst_n, d (async input), q (synchronized, resets to idle-high 4'hF).
module keypad_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d,
    output logic [3:0] q
);
    logic [3:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates column drive, snapshots rows, debounces whole scans, emits press events.
// Latency: key_valid/key_down change 2 cycles after the scan end that completes the debounce run.
// Backpressure: none; key_valid is a single-cycle pulse, key_char holds the last accepted key.
// Ports: clk, rst_n, kp (keypad_if.master: col out, row in, key_char/key_valid/key_down out).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 10
) (
    input  logic     clk,
    input  logic     rst_n,
    keypad_if.master kp
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    logic [3:0]    row_sync;
    logic [CW-1:0] dwell_cnt;
    logic [1:0]    col_idx;
    logic [3:0]    col_q;
    logic [15:0]   snapshot;
    logic          scan_done;
    logic          dwell_last;

    res_kind_t     cur_kind, prev_kind;
    logic [3:0]    cur_pos, prev_pos;
    logic [4:0]    ones;
    logic [3:0]    pos_any;
    logic [SW-1:0] stable_cnt, stable_nxt;
    logic          same_result;

    state_t        state_q, state_d;
    logic          press_evt;
    logic [7:0]    key_char_q;
    logic          key_valid_q;

    keypad_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (kp.row),
        .q     (row_sync)
    );

    assign dwell_last = (dwell_cnt == DWELL_LAST);

    // Sampling at the last dwell cycle leaves the synchronizer two full
    // cycles to settle on the current column's rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
            col_idx   <= 2'd0;
            col_q     <= COL_RESET;
            snapshot  <= '0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= dwell_last && (col_idx == 2'd3);
            if (dwell_last) begin
                dwell_cnt                   <= '0;
                snapshot[{col_idx, 2'b00} +: 4] <= ~row_sync;
                col_idx                     <= col_idx + 2'd1;
                col_q                       <= {col_q[2:0], col_q[3]};
            end else begin
                dwell_cnt <= dwell_cnt + CW'(1);
            end
        end
    end

    // Snapshot bit index is col*4 + row. Position is kept only for SINGLE so
    // that NONE/MULTI compare equal regardless of which bits were set.
    always_comb begin
        ones     = '0;
        pos_any  = '0;
        cur_kind = RES_NONE;
        cur_pos  = '0;
        for (int i = 0; i < 16; i++) begin
            if (snapshot[i]) begin
                ones    = ones + 5'd1;
                pos_any = 4'(i);
            end
        end
        if (ones == 5'd1) begin
            cur_kind = RES_SINGLE;
            cur_pos  = pos_any;
        end else if (ones > 5'd1) begin
            cur_kind = RES_MULTI;
        end
    end

    assign same_result = (cur_kind == prev_kind) && (cur_pos == prev_pos);
    assign stable_nxt  = !same_result              ? SW'(1) :
                         (stable_cnt == STABLE_MAX) ? STABLE_MAX :
                                                      stable_cnt + SW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_kind  <= RES_NONE;
            prev_pos   <= '0;
            stable_cnt <= '0;
        end else if (scan_done) begin
            prev_kind  <= cur_kind;
            prev_pos   <= cur_pos;
            stable_cnt <= stable_nxt;
        end
    end

    // FSM decides on the same cycle the run length is updated, so outputs
    // move one cycle later (two after the scan end).
    always_comb begin
        state_d   = state_q;
        press_evt = 1'b0;
        if (scan_done && (stable_nxt == STABLE_MAX)) begin
            case (state_q)
                ST_IDLE: begin
                    if (cur_kind == RES_SINGLE) begin
                        state_d   = ST_PRESSED;
                        press_evt = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (cur_kind == RES_NONE) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            key_char_q  <= 8'h00;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_valid_q <= press_evt;
            if (press_evt) begin
                key_char_q <= {4'h0, key_code(cur_pos[1:0], cur_pos[3:2])};
            end
        end
    end

    assign kp.col       = col_q;
    assign kp.key_char  = key_char_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = (state_q == ST_PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulates the key matrix, predicts outputs per cycle from scan-level rules.
// Latency: n/a.
// Backpressure: n/a.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DB = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_if kp ();

    // Held keys, bit index = row*4 + col.
    logic [15:0] keys = '0;

    // Ideal switch matrix: a row reads low when a held key on it sits in the driven column.
    always_comb begin
        kp.row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            kp.row[r] = ~|(keys[r*4 +: 4] & ~kp.col);
        end
    end

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp)
    );

    localparam logic [7:0] CHARS [16] = '{
        8'h01, 8'h02, 8'h03, 8'h0A,
        8'h04, 8'h05, 8'h06, 8'h0B,
        8'h07, 8'h08, 8'h09, 8'h0C,
        8'h0E, 8'h00, 8'h0F, 8'h0D
    };

    typedef struct {
        logic [15:0] ma;      // keys on even scans of the step
        logic [15:0] mb;      // keys on odd scans of the step
        int          nscans;
        int          pulses;  // key_valid pulses caused by this step
        logic [7:0]  chr;     // key_char after the step
        bit          down;    // key_down after the step
    } step_t;

    step_t steps [13];

    int tests = 0;
    int fails = 0;
    int n;                 // cycles since reset release
    logic [15:0] this_mask, last_mask;
    int   prev_res;        // -1 none, 0..15 single key, 16 multi
    int   run_len;
    bit   exp_down, exp_valid;
    logic [7:0] exp_char;
    int   pulses = 0;
    int   pulse_base = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
        end
    endtask

    function automatic int classify(input logic [15:0] m);
        int k;
        k = -1;
        if ($countones(m) == 0) return -1;
        if ($countones(m) > 1) return 16;
        for (int i = 0; i < 16; i++) if (m[i]) k = i;
        return k;
    endfunction

    task automatic model_reset();
        n         = 0;
        prev_res  = -1;
        run_len   = 0;
        exp_down  = 0;
        exp_valid = 0;
        exp_char  = 8'h00;
    endtask

    task automatic model_scan_end(input logic [15:0] m);
        int res;
        res = classify(m);
        if (res == prev_res) run_len = (run_len >= DB) ? DB : run_len + 1;
        else                 run_len = 1;
        prev_res = res;
        if (run_len == DB) begin
            if (!exp_down && res >= 0 && res < 16) begin
                exp_down  = 1;
                exp_valid = 1;
                exp_char  = CHARS[res];
            end else if (exp_down && res == -1) begin
                exp_down = 0;
            end
        end
    endtask

    // Called at a falling edge; checks the current cycle then advances one cycle.
    task automatic run_cycle(input logic [15:0] m);
        int off;
        logic [3:0] one, ec;
        off = n % (4*SD);
        if (off == 0) begin
            last_mask = this_mask;
            this_mask = m;
        end
        keys      = m;
        exp_valid = 0;
        if (off == 1 && n > 4*SD) model_scan_end(last_mask);
        one = 4'b0001;
        ec  = ~(one << ((n / SD) % 4));
        #1;
        check("col", int'(kp.col), int'(ec));
        check("key_valid", int'(kp.key_valid), int'(exp_valid));
        check("key_down", int'(kp.key_down), int'(exp_down));
        check("key_char", int'(kp.key_char), int'(exp_char));
        if (kp.key_valid) pulses++;
        @(posedge clk);
        @(negedge clk);
        n++;
    endtask

    task automatic run_scans(input logic [15:0] m, input int cnt);
        for (int s = 0; s < cnt; s++)
            for (int j = 0; j < 4*SD; j++) run_cycle(m);
    endtask

    task automatic check_step(input int i);
        check($sformatf("step%0d_pulses", i), pulses - pulse_base, steps[i].pulses);
        check($sformatf("step%0d_char", i), int'(kp.key_char), int'(steps[i].chr));
        check($sformatf("step%0d_down", i), int'(kp.key_down), int'(steps[i].down));
        pulse_base = pulses;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"}, int'(kp.col), 4'b1110);
        check({tag, "_char"}, int'(kp.key_char), 8'h00);
        check({tag, "_valid"}, int'(kp.key_valid), 0);
        check({tag, "_down"}, int'(kp.key_down), 0);
    endtask

    localparam logic [15:0] K12 = 16'h0040;  // row1,col2 -> 6
    localparam logic [15:0] K31 = 16'h2000;  // row3,col1 -> 0
    localparam logic [15:0] K00 = 16'h0001;  // row0,col0 -> 1
    localparam logic [15:0] K03 = 16'h0008;  // row0,col3 -> A
    localparam logic [15:0] K20 = 16'h0100;  // row2,col0 -> 7
    localparam logic [15:0] K11 = 16'h0020;  // row1,col1 -> 5

    initial begin
        int pb, a, b, kind, hold;
        logic [15:0] m;

        steps[0]  = '{16'h0,    16'h0,    5, 0, 8'h00, 1'b0};
        steps[1]  = '{K12,      K12,      5, 1, 8'h06, 1'b1};
        steps[2]  = '{16'h0,    16'h0,    4, 0, 8'h06, 1'b0};
        steps[3]  = '{K31,      16'h0,    8, 0, 8'h06, 1'b0};
        steps[4]  = '{K31,      K31,      4, 1, 8'h00, 1'b1};
        steps[5]  = '{16'h0,    16'h0,    4, 0, 8'h00, 1'b0};
        steps[6]  = '{K00|K03,  K00|K03,  6, 0, 8'h00, 1'b0};
        steps[7]  = '{K00,      K00,      4, 1, 8'h01, 1'b1};
        steps[8]  = '{16'h0,    16'h0,    4, 0, 8'h01, 1'b0};
        steps[9]  = '{K20,      K20,      4, 1, 8'h07, 1'b1};
        steps[10] = '{K11,      K11,      4, 0, 8'h07, 1'b1};
        steps[11] = '{16'h0,    16'h0,    4, 0, 8'h07, 1'b0};
        steps[12] = '{K20,      K20,      4, 1, 8'h07, 1'b1};

        model_reset();
        this_mask = '0;
        last_mask = '0;
        keys      = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 13; i++) begin
            for (int s = 0; s < steps[i].nscans; s++) begin
                m = (s % 2 == 1) ? steps[i].mb : steps[i].ma;
                for (int j = 0; j < 4*SD; j++) begin
                    run_cycle(m);
                    if (s == 0 && j == 1 && i > 0) check_step(i - 1);
                end
            end
        end
        run_cycle(K20);
        run_cycle(K20);
        check_step(12);
        repeat (5) run_cycle(K20);

        // Reset while PRESSED: outputs drop without waiting for a clock edge.
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        pb = pulses;
        run_scans(K20, 4);
        run_cycle(K20);
        run_cycle(K20);
        check("reheld_pulses", pulses - pb, 1);
        check("reheld_char", int'(kp.key_char), 8'h07);
        check("reheld_down", int'(kp.key_down), 1);

        // Random holds of zero, one or two keys (two keys cannot ghost).
        // First scan of this block is mid-scan aligned; restart scan alignment by resetting.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 2);
            a    = $urandom_range(0, 15);
            b    = (a + 1 + $urandom_range(0, 14)) % 16;
            m    = '0;
            if (kind >= 1) m[a] = 1'b1;
            if (kind == 2) m[b] = 1'b1;
            hold = $urandom_range(1, 5);
            run_scans(m, hold);
        end
        run_scans(16'h0, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
